crc_encode_sched: RTL
=====================

Name: crc_encode_sched

Overview:
- Round-robin scheduler that shares one crc4encoder instance among NREQ requesters.
- Accepts a message and generator polynomial from one requester at a time and pulses the encoder's ctrlen.
- Waits for the encoder's calculation to finish, with a timeout guard.
- Returns the CRC, the requester ID and an error flag on a valid/ready response channel.
- Sits between the packet-side requesters and the encoder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATAWIDTH, 10, message width; must match the encoder.
- CRCWIDTH, 4, CRC width; genPoly is CRCWIDTH+1 bits.
- TIMEOUT, 31, maximum RUN cycles before the job is aborted; must be > DATAWIDTH+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, at most one bit high
- req_data  in  NREQ*DATAWIDTH  packed messages; requester i at [i*DATAWIDTH +: DATAWIDTH]
- req_poly  in  NREQ*(CRCWIDTH+1)  packed generator polynomials
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NREQ)  requester index of the response
- rsp_crc  out  CRCWIDTH  CRC result
- rsp_err  out  1  job timed out; rsp_crc is invalid
- enc_ctrlen  out  1  encoder load strobe
- enc_datain  out  DATAWIDTH  encoder message input
- enc_genpoly  out  CRCWIDTH+1  encoder polynomial input
- enc_crcseq  in  CRCWIDTH  encoder CRC output
- enc_crcready  in  1  encoder idle flag
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values:
  - state IDLE; round-robin pointer 0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_crc, rsp_err, enc_ctrlen, enc_datain, enc_genpoly, busy, timeout_err.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from the pointer upward modulo NREQ.
  - req_ready[g] is driven combinationally in IDLE only.
  - On the accepting edge: capture req_data/req_poly of g into enc_datain/enc_genpoly, store g, set pointer to (g+1) mod NREQ, go to LOAD.
  - With no valid request, stay in IDLE.
- LOAD (1 cycle):
  - enc_ctrlen=1; enc_datain and enc_genpoly are stable from the accepting edge until the next acceptance.
  - Clear the run counter and seen_busy; go to RUN.
- RUN:
  - Run counter increments every cycle, saturating at TIMEOUT.
  - seen_busy sets when enc_crcready=0.
  - Completion is seen_busy=1 and enc_crcready=1. On completion: rsp_crc<=enc_crcseq, rsp_err<=0, go to RESP.
  - enc_crcready=1 before seen_busy is ignored.
  - If the counter reaches TIMEOUT without completion: rsp_err<=1, rsp_crc<=0, timeout_err<=1, go to RESP.
  - If completion and timeout occur on the same edge, completion wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_crc and rsp_err are held stable until rsp_valid and rsp_ready are both high on an edge.
  - On that handshake edge: rsp_valid<=0, go to IDLE.
  - No new grant is issued while in RESP.
  - Arbitration resumes in the IDLE cycle after the handshake, so back-to-back jobs have one IDLE cycle between them.
- Latency with the default encoder: acceptance edge E0, ctrlen sampled at E1, encoder finishes at E11, completion captured at E12. rsp_valid is high from E12, i.e. DATAWIDTH+2 edges after acceptance.
- Fairness: pointer advances only on a grant. A requester dropping req_valid before its grant loses no fairness.
- req_valid falling while req_ready is high is a protocol violation; behaviour is unspecified.
- Asynchronous reset mid-job:
  - Immediate return to IDLE, all outputs cleared; no response is issued for the aborted job.
  - The encoder's reset is driven separately at the top level.

Test Plan:
- Single request: requester 2, data 10'b1101011011, poly 5'b10011 -> rsp_valid 12 cycles after acceptance, rsp_id=2, rsp_crc=4'b1110, rsp_err=0; enc_ctrlen high exactly 1 cycle.
- Contention: all four requesters valid continuously from reset -> grant order 0,1,2,3,0; each req_ready a 1-cycle pulse; one IDLE cycle between jobs.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_id/rsp_crc stable, no req_ready asserted; release -> handshake, next grant one cycle later.
- Stuck encoder: hold enc_crcready=0 -> rsp_valid with rsp_err=1, rsp_crc=0 after TIMEOUT RUN cycles; timeout_err stays 1 across later good jobs until reset.
- Spurious ready: enc_crcready held 1 for the first 3 RUN cycles, then real encoder behaviour -> no early completion; correct CRC delivered.
- Reset mid-RUN: assert reset 5 cycles into RUN -> outputs 0 asynchronously, state IDLE, pointer 0; next request is served normally.

Source files
------------

// File: rtl/crc_encode_sched.sv
// Round-robin scheduler sharing one crc4encoder among NREQ requesters; returns CRC, id and timeout flag.
// Latency: response valid DATAWIDTH+2 edges after acceptance with a default encoder (TIMEOUT+1 when stuck).
// Backpressure: a held response (rsp_ready low) blocks all new grants; req_ready only asserts in IDLE.
module crc_encode_sched #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 10,
    parameter int CRCWIDTH  = 4,
    parameter int TIMEOUT   = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*DATAWIDTH-1:0]     req_data,
    input  logic [NREQ*(CRCWIDTH+1)-1:0]  req_poly,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [CRCWIDTH-1:0]           rsp_crc,
    output logic                          rsp_err,
    output logic                          enc_ctrlen,
    output logic [DATAWIDTH-1:0]          enc_datain,
    output logic [CRCWIDTH:0]             enc_genpoly,
    input  logic [CRCWIDTH-1:0]           enc_crcseq,
    input  logic                          enc_crcready,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    logic [1:0]           state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [DATAWIDTH-1:0] dat_q, dat_d;
    logic [CRCWIDTH:0]    poly_q, poly_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 seen_busy_q, seen_busy_d;
    logic [CRCWIDTH-1:0]  crc_q, crc_d;
    logic                 err_q, err_d;
    logic                 terr_q, terr_d;

    logic                 gnt_vld;
    logic [IDW-1:0]       gnt_idx;
    logic [DATAWIDTH-1:0] gnt_dat;
    logic [CRCWIDTH:0]    gnt_poly;
    logic [IDW:0]         scan;

    // Round-robin search from the pointer, then mux out the winner's payload and ready.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        gnt_dat   = '0;
        gnt_poly  = '0;
        scan      = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!gnt_vld && req_valid[scan[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[IDW-1:0];
            end
        end
        for (int m = 0; m < NREQ; m++) begin
            if (gnt_vld && gnt_idx == IDW'(m)) begin
                gnt_dat      = req_data[m*DATAWIDTH +: DATAWIDTH];
                gnt_poly     = req_poly[m*(CRCWIDTH+1) +: CRCWIDTH+1];
                req_ready[m] = (state_q == ST_IDLE);
            end
        end
    end

    // Job sequencing: accept, strobe the encoder, wait for busy-then-idle or timeout, hold response.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        dat_d       = dat_q;
        poly_d      = poly_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        crc_d       = crc_q;
        err_d       = err_q;
        terr_d      = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    dat_d   = gnt_dat;
                    poly_d  = gnt_poly;
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_LAST) ? '0 : gnt_idx + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d       = '0;
                seen_busy_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                seen_busy_d = seen_busy_q | ~enc_crcready;
                // An idle flag before the encoder has gone busy is stale from the previous job.
                if (seen_busy_q && enc_crcready) begin
                    crc_d   = enc_crcseq;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    crc_d   = '0;
                    err_d   = 1'b1;
                    terr_d  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; async reset abandons any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            dat_q       <= '0;
            poly_q      <= '0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            crc_q       <= '0;
            err_q       <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            dat_q       <= dat_d;
            poly_q      <= poly_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            terr_q      <= terr_d;
        end
    end

    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_crc     = crc_q;
    assign rsp_err     = err_q;
    assign enc_ctrlen  = (state_q == ST_LOAD);
    assign enc_datain  = dat_q;
    assign enc_genpoly = poly_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule
